// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative HI/LO multiply/divide unit.
//
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) over 32 iterations.
// MTHI/MTLO write HI/LO directly in a single cycle.
//
// Build option: define MULDIV_DIV_EN to compile in the divider. Without it,
// DIV/DIVU leave all state alone and pulse o_err instead.
//
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_start, i_op        request and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                        4 MTHI, 5 MTLO, 6/7 ignored)
//   i_r, i_s             operand A (also MTHI/MTLO data), operand B
//   i_flush              abort the operation in flight
//   o_hi, o_lo           HI/LO result registers
//   o_busy               iterative operation in flight
//   o_done               one-cycle completion pulse
//   o_err                one-cycle unsupported-opcode pulse
module muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_r,
    input  logic [31:0] i_s,
    input  logic        i_flush,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [63:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opb;      // mul: |multiplicand|; div: |divisor|
    logic        neg_res;  // negate product / quotient at the end

    // Operand signs and magnitudes, taken straight from the request.
    logic        signed_op, sgn_a, sgn_b;
    logic [31:0] mag_a, mag_b;
    assign signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign sgn_a     = signed_op & i_r[31];
    assign sgn_b     = signed_op & i_s[31];
    assign mag_a     = sgn_a ? (32'd0 - i_r) : i_r;
    assign mag_b     = sgn_b ? (32'd0 - i_s) : i_s;

    // Shift-add step: conditionally add multiplicand into the top half, shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next, prod;
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};
    assign prod     = neg_res ? (64'd0 - mul_next) : mul_next;

    logic [63:0] acc_next;
    logic [31:0] res_hi, res_lo;

`ifdef MULDIV_DIV_EN
    logic        is_div;
    logic        neg_rem;  // remainder takes the dividend's sign
    logic [31:0] opa;      // raw dividend, returned as HI on divide by zero

    // Restoring step: shift {rem,quo} left, try subtracting the divisor.
    // The shifted remainder is always below 2*divisor, so bit 32 of the
    // trial difference is set exactly when the subtraction underflows.
    logic [64:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    assign div_shift = {acc, 1'b0};
    assign div_trial = div_shift[64:32] - {1'b0, opb};
    assign div_next  = div_trial[32] ? div_shift[63:0]
                                     : {div_trial[31:0], div_shift[31:1], 1'b1};

    always_comb begin
        acc_next = is_div ? div_next : mul_next;
        res_hi   = prod[63:32];
        res_lo   = prod[31:0];
        if (is_div) begin
            if (opb == 32'd0) begin
                res_hi = opa;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = neg_rem ? (32'd0 - div_next[63:32]) : div_next[63:32];
                res_lo = neg_res ? (32'd0 - div_next[31:0])  : div_next[31:0];
            end
        end
    end

    assign o_err = 1'b0;
`else
    always_comb begin
        acc_next = mul_next;
        res_hi   = prod[63:32];
        res_lo   = prod[31:0];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            count   <= 5'd0;
            acc     <= 64'd0;
            opb     <= 32'd0;
            neg_res <= 1'b0;
            o_hi    <= 32'd0;
            o_lo    <= 32'd0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div  <= 1'b0;
            neg_rem <= 1'b0;
            opa     <= 32'd0;
`else
            o_err   <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef MULDIV_DIV_EN
`else
            o_err  <= 1'b0;
`endif
            case (state)
                IDLE: if (i_start && !i_flush) begin
                    case (i_op)
                        OP_MULT, OP_MULTU: begin
                            state   <= RUN;
                            o_busy  <= 1'b1;
                            count   <= 5'd0;
                            acc     <= {32'd0, mag_b};
                            opb     <= mag_a;
                            neg_res <= sgn_a ^ sgn_b;
`ifdef MULDIV_DIV_EN
                            is_div  <= 1'b0;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                            state   <= RUN;
                            o_busy  <= 1'b1;
                            count   <= 5'd0;
                            acc     <= {32'd0, mag_a};
                            opb     <= mag_b;
                            neg_res <= sgn_a ^ sgn_b;
                            neg_rem <= sgn_a;
                            opa     <= i_r;
                            is_div  <= 1'b1;
`else
                            o_err   <= 1'b1;
`endif
                        end
                        OP_MTHI: o_hi <= i_r;
                        OP_MTLO: o_lo <= i_r;
                        default: ;
                    endcase
                end
                RUN: begin
                    if (i_flush) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        count  <= 5'd0;
                    end else begin
                        acc   <= acc_next;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            o_hi   <= res_hi;
                            o_lo   <= res_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed and randomized checks of muldiv_unit against an
// arithmetic reference model (SV integer multiply/divide on 64-bit values).
module tb_muldiv_unit;
    logic        i_clk, i_rst_n, i_start, i_flush;
    logic [2:0]  i_op;
    logic [31:0] i_r, i_s, o_hi, o_lo;
    logic        o_busy, o_done, o_err;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    muldiv_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_r(i_r), .i_s(i_s), .i_flush(i_flush), .o_hi(o_hi), .o_lo(o_lo),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {HI,LO} from the architectural definition of each opcode.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] r, input logic [31:0] s);
        longint a, b, q, m;
        logic [63:0] res;
        res = 64'd0;
        case (op)
            3'd0: begin
                a = longint'($signed(r)); b = longint'($signed(s));
                res = a * b;
            end
            3'd1: res = {32'd0, r} * {32'd0, s};
            3'd2: begin
                if (s == 32'd0) res = {r, 32'hFFFF_FFFF};
                else begin
                    a = longint'($signed(r)); b = longint'($signed(s));
                    q = a / b; m = a % b;
                    res = {m[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (s == 32'd0) res = {r, 32'hFFFF_FFFF};
                else res = {r % s, r / s};
            end
            default: res = {exp_hi, exp_lo};
        endcase
        return res;
    endfunction

    // Issue one arithmetic op (called just after a rising edge) and check it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] r, input logic [31:0] s, input string tag);
        logic [63:0] e;
        int cyc;
        e = model(op, r, s);
        i_start = 1'b1; i_op = op; i_r = r; i_s = s;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        if (op <= 3'd1 || DIV_EN) begin
            cyc = 0;
            while (!o_done && cyc < 40) begin
                if (cyc == 16) begin
                    chk({tag, " hold"}, {o_hi, o_lo}, {exp_hi, exp_lo});
                    chk({tag, " busy"}, 64'(o_busy), 64'd1);
                end
                @(posedge i_clk); #1;
                cyc++;
            end
            chk({tag, " cycles"}, 64'(cyc), 64'd32);
            chk({tag, " result"}, {o_hi, o_lo}, e);
            chk({tag, " busy end"}, 64'(o_busy), 64'd0);
            exp_hi = e[63:32]; exp_lo = e[31:0];
            @(posedge i_clk); #1;
            chk({tag, " done pulse"}, 64'(o_done), 64'd0);
        end else begin
            chk({tag, " err"}, {o_err, o_busy, o_done}, {1'b1, 1'b0, 1'b0});
            chk({tag, " regs"}, {o_hi, o_lo}, {exp_hi, exp_lo});
            @(posedge i_clk); #1;
            chk({tag, " err pulse"}, {o_err, o_done}, 64'd0);
        end
    endtask

    initial begin
        int dones;
        logic [2:0]  rop;
        logic [31:0] rr, rs;
        i_rst_n = 1'b0; i_start = 1'b0; i_flush = 1'b0;
        i_op = 3'd0; i_r = 32'd0; i_s = 32'd0;
        #12;
        chk("reset outputs", {o_hi, o_lo}, 64'd0);
        chk("reset flags", {o_busy, o_done, o_err}, 64'd0);
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, "MULT -2*3");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULTU max");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
        run_op(3'd3, 32'd100, 32'd0, "DIVU 100/0");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "DIV min/-1");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0, "DIV -7/0");

        // MTHI in IDLE
        i_start = 1'b1; i_op = 3'd4; i_r = 32'h1234;
        @(posedge i_clk); #1; i_start = 1'b0;
        chk("MTHI idle", {o_hi, o_lo}, {32'h1234, exp_lo});
        chk("MTHI flags", {o_busy, o_done, o_err}, 64'd0);
        exp_hi = 32'h1234;
        i_start = 1'b1; i_op = 3'd5; i_r = 32'hCAFE_0001;
        @(posedge i_clk); #1; i_start = 1'b0;
        chk("MTLO idle", {o_hi, o_lo}, {exp_hi, 32'hCAFE_0001});
        exp_lo = 32'hCAFE_0001;

        // Opcodes 6/7 ignored
        i_start = 1'b1; i_op = 3'd6; i_r = 32'h5555;
        @(posedge i_clk); #1; i_op = 3'd7;
        @(posedge i_clk); #1; i_start = 1'b0;
        chk("op6/7 regs", {o_hi, o_lo}, {exp_hi, exp_lo});
        chk("op6/7 flags", {o_busy, o_done, o_err}, 64'd0);

        // Flush together with start in IDLE: start discarded
        i_start = 1'b1; i_flush = 1'b1; i_op = 3'd4; i_r = 32'h9999;
        @(posedge i_clk); #1; i_start = 1'b0; i_flush = 1'b0;
        chk("flush+start", {31'd0, o_busy, o_hi}, {32'd0, exp_hi});

        // MTHI and MULT starts during RUN are ignored
        i_start = 1'b1; i_op = 3'd0; i_r = 32'd7; i_s = 32'd9;
        @(posedge i_clk); #1;
        i_op = 3'd4; i_r = 32'h1234;
        repeat (3) @(posedge i_clk); #1;
        i_start = 1'b0;
        chk("MTHI in RUN", {o_hi, o_lo}, {exp_hi, exp_lo});
        dones = 0;
        for (int k = 0; k < 40 && dones == 0; k++) begin
            @(posedge i_clk); #1;
            if (o_done) dones = k + 4;
        end
        chk("start in RUN cycles", 64'(dones), 64'd32);
        chk("start in RUN result", {o_hi, o_lo}, 64'd63);
        exp_hi = 32'd0; exp_lo = 32'd63;

        // Flush at T10
        i_start = 1'b1; i_op = 3'd1; i_r = 32'hDEAD; i_s = 32'hBEEF;
        @(posedge i_clk); #1; i_start = 1'b0;
        repeat (9) @(posedge i_clk); #1;
        chk("pre-flush busy", 64'(o_busy), 64'd1);
        i_flush = 1'b1;
        @(posedge i_clk); #1; i_flush = 1'b0;
        chk("flush busy", 64'(o_busy), 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_done) dones++;
            @(posedge i_clk); #1;
        end
        chk("flush no done", 64'(dones), 64'd0);
        chk("flush regs", {o_hi, o_lo}, {exp_hi, exp_lo});

        // Reset at T15 of a DIVU (MULTU when no divider)
        i_start = 1'b1; i_op = DIV_EN ? 3'd3 : 3'd1; i_r = 32'd1000; i_s = 32'd7;
        @(posedge i_clk); #1; i_start = 1'b0;
        repeat (14) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid reset regs", {o_hi, o_lo}, 64'd0);
        chk("mid reset flags", {o_busy, o_done, o_err}, 64'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        #10 i_rst_n = 1'b1;
        i_start = 1'b1; i_op = 3'd1; i_r = 32'd5; i_s = 32'd6;
        @(posedge i_clk); #1; i_start = 1'b0;
        chk("post reset accept", {o_busy, o_done}, {1'b1, 1'b0});
        dones = 0;
        for (int k = 0; k < 40 && dones == 0; k++) begin
            @(posedge i_clk); #1;
            if (o_done) dones = k + 1;
        end
        chk("post reset cycles", 64'(dones), 64'd32);
        chk("post reset result", {o_hi, o_lo}, 64'd30);
        exp_hi = 32'd0; exp_lo = 32'd30;
        @(posedge i_clk); #1;

        // Randomized operations
        for (int n = 0; n < 16; n++) begin
            rop = 3'($urandom_range(0, 3));
            rr  = $urandom;
            rs  = $urandom;
            if (n % 4 == 1) rs = rs >> $urandom_range(8, 31);
            if (n % 5 == 2) rs = 32'd0;
            if (n % 3 == 0) rr = ~rr;
            run_op(rop, rr, rs, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port i_clk  input  1  block clock; all state changes on the rising edge.
REQ-003 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-004 Port i_start  input  1  operation request, sampled every rising edge.
REQ-005 Port i_op  input  3  opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
REQ-006 Port i_r  input  32  operand A: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 Port i_s  input  32  operand B: multiplier or divisor.
REQ-008 Port i_flush  input  1  abort request for an in-flight operation.
REQ-009 Port o_hi  output  32  HI register.
REQ-010 Port o_lo  output  32  LO register.
REQ-011 Port o_busy  output  1  iterative operation in flight.
REQ-012 Port o_done  output  1  one-cycle completion pulse.
REQ-013 Port o_err  output  1  one-cycle pulse for an unsupported opcode.

Function
REQ-014 States SHALL be IDLE and RUN only.
REQ-015 i_start is accepted only in IDLE with i_flush low; the accepting edge is T0.
- Start during RUN SHALL be ignored and not queued.
REQ-016 MULT, MULTU, DIV or DIVU accepted at T0 SHALL:
- latch operands and record operand signs;
- enter RUN;
- assert o_busy from after T0 until edge T32.
REQ-017 Each RUN edge T1..T32 SHALL perform one iteration:
- multiply: shift-add over a 64-bit accumulator;
- divide: restoring, one quotient bit per iteration.
REQ-018 At T32 the block SHALL:
- write HI and LO;
- return to IDLE with o_busy low;
- drive o_done high for exactly the cycle after T32.
REQ-019 Result placement: MULT/MULTU put {HI,LO} = 64-bit product; DIV/DIVU put LO = quotient and HI = remainder.
REQ-020 Signed operations SHALL use magnitudes internally and apply signs at T32:
- product sign = sign(A) XOR sign(B);
- quotient sign = sign(A) XOR sign(B);
- remainder sign = sign(A).
REQ-021 Divide by zero SHALL take the full 32 cycles and give LO=32'hFFFFFFFF, HI=i_r as latched; this applies to DIV and DIVU.
REQ-022 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0, with no error indication.
REQ-023 MTHI/MTLO accepted at T0 SHALL write i_r into HI/LO at T0, with no busy, no done and no state change.
REQ-024 Opcodes 6 and 7 SHALL be ignored: no state change, no o_done, no o_err.
REQ-025 i_flush high in RUN SHALL:
- return the block to IDLE at that edge;
- drop o_busy the following cycle;
- leave HI/LO unchanged and produce no o_done.
REQ-026 i_flush and i_start together SHALL act as flush only; the start is discarded.
REQ-027 o_hi and o_lo SHALL change only at T32 writes, MTHI/MTLO writes, or reset.
- They SHALL hold their value throughout RUN.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately force:
- state IDLE;
- o_hi=0, o_lo=0, o_busy=0, o_done=0, o_err=0;
- all internal iteration counters and accumulators to zero.
REQ-029 Reset asserted mid-operation SHALL discard that operation; no o_done follows reset release.
REQ-030 The first start SHALL be accepted at the first rising edge after i_rst_n goes high.

Configuration
REQ-031 The macro MULDIV_DIV_EN SHALL select whether the divider is compiled in.
- Defined: the divider is present and DIV/DIVU behave as REQ-016 to REQ-022; o_err is tied 0.
- Undefined: no divider logic is present.
- Undefined: DIV/DIVU accepted in IDLE leave HI/LO and state unchanged and pulse o_err for the cycle after T0.
- Undefined: o_done stays 0 for DIV/DIVU.
REQ-032 Multiply and MTHI/MTLO behaviour SHALL be identical in both builds.

Verification
REQ-033 MULT i_r=32'hFFFFFFFE (-2), i_s=3 -> o_busy for 32 cycles; o_done in cycle 33; HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-034 MULTU i_r=i_s=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-035 DIV i_r=-7, i_s=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU 100/0 -> LO=32'hFFFFFFFF, HI=100.
REQ-036 MTHI 32'h1234 during RUN is ignored; MTHI 32'h1234 in IDLE gives HI=32'h1234 next cycle with no o_done.
REQ-037 MULT started, i_flush at T10 -> o_busy low from cycle 11; HI/LO keep their prior values; no o_done.
REQ-038 i_rst_n low at T15 of a DIVU -> all outputs 0 immediately; no o_done after release; a new start is accepted on the first edge after release.
